// File: rtl/mbed_serial_receiver_pkg.sv
// Shared definitions for the mbed serial link receiver: instruction word layout,
// receiver FSM encoding and the default word width.
package mbed_serial_receiver_pkg;
   localparam int DEFAULT_DATA_W = 11;

   localparam int ACT_BIT   = 10;
   localparam int MODE_BIT  = 9;
   localparam int SERVO_BIT = 8;
   localparam int VALUE_MSB = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } rx_state_t;
endpackage

// File: rtl/mbed_serial_receiver_if.sv
// Link and instruction-word bundle between the mbed side and the receiver.
interface mbed_serial_receiver_if
   import mbed_serial_receiver_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
);
   logic              set_bit;
   logic              input_bit;
   logic [DATA_W-1:0] mbed_data;
   logic              data_valid;
   logic              data_strobe;
   logic              parity_err;
   logic              frame_err;

   modport master (
      output set_bit, input_bit,
      input  mbed_data, data_valid, data_strobe, parity_err, frame_err
   );

   modport slave (
      input  set_bit, input_bit,
      output mbed_data, data_valid, data_strobe, parity_err, frame_err
   );
endinterface

// File: rtl/mbed_serial_receiver_bit_synchronizer.sv
// Multi-flop synchroniser for one asynchronous link line into the clk domain.
module bit_synchronizer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [SYNC_STAGES-1:0] sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_reg[SYNC_STAGES-1];
endmodule

// File: rtl/mbed_serial_receiver.sv
// Deserialises the mbed strobe/data link into a held instruction word with
// valid/strobe flags, optional odd parity and an in-frame stall timeout.
module mbed_serial_receiver
   import mbed_serial_receiver_pkg::*;
#(
   parameter int DATA_W         = DEFAULT_DATA_W,
   parameter int PARITY_EN      = 1,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mbed_serial_receiver_if.slave link
);
   localparam int FRAME_LEN = DATA_W + PARITY_EN;
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);
   localparam int TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic set_sync;
   logic data_sync;
   logic set_prev_reg;
   logic edge_reg;
   logic bit_reg;

   rx_state_t            state_reg, state_next;
   logic [FRAME_LEN-1:0] shift_reg, shift_next;
   logic [CNT_W-1:0]     count_reg, count_next;
   logic [TO_W-1:0]      tcount_reg, tcount_next;
   logic [DATA_W-1:0]    data_reg, data_next;
   logic                 valid_reg, valid_next;
   logic                 strobe_reg, strobe_next;
   logic                 perr_reg, perr_next;
   logic                 ferr_reg, ferr_next;
   logic                 parity_ok;

   bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_set (
      .clk(clk), .rst_n(rst_n), .d(link.set_bit), .q(set_sync)
   );

   bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
      .clk(clk), .rst_n(rst_n), .d(link.input_bit), .q(data_sync)
   );

   // Edge and its data sample are registered together so the FSM sees a clean pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_prev_reg <= 1'b0;
         edge_reg     <= 1'b0;
         bit_reg      <= 1'b0;
      end else begin
         set_prev_reg <= set_sync;
         edge_reg     <= set_sync & ~set_prev_reg;
         bit_reg      <= data_sync;
      end
   end

   assign parity_ok = (PARITY_EN == 0) || (^shift_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         shift_reg  <= '0;
         count_reg  <= '0;
         tcount_reg <= '0;
         data_reg   <= '0;
         valid_reg  <= 1'b0;
         strobe_reg <= 1'b0;
         perr_reg   <= 1'b0;
         ferr_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         shift_reg  <= shift_next;
         count_reg  <= count_next;
         tcount_reg <= tcount_next;
         data_reg   <= data_next;
         valid_reg  <= valid_next;
         strobe_reg <= strobe_next;
         perr_reg   <= perr_next;
         ferr_reg   <= ferr_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      shift_next  = shift_reg;
      count_next  = count_reg;
      tcount_next = tcount_reg;
      data_next   = data_reg;
      valid_next  = valid_reg;
      strobe_next = 1'b0;
      perr_next   = 1'b0;
      ferr_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (edge_reg) begin
               shift_next  = {shift_reg[FRAME_LEN-2:0], bit_reg};
               count_next  = CNT_W'(1);
               tcount_next = '0;
               state_next  = SHIFT;
            end
         end
         SHIFT: begin
            if (edge_reg) begin
               shift_next  = {shift_reg[FRAME_LEN-2:0], bit_reg};
               count_next  = count_reg + 1'b1;
               tcount_next = '0;
               if (count_reg == CNT_W'(FRAME_LEN - 1)) begin
                  state_next = CHECK;
               end
            end else if (tcount_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
               ferr_next   = 1'b1;
               valid_next  = 1'b0;
               count_next  = '0;
               tcount_next = '0;
               state_next  = IDLE;
            end else if (tcount_reg != {TO_W{1'b1}}) begin
               tcount_next = tcount_reg + 1'b1;
            end
         end
         CHECK: begin
            if (parity_ok) begin
               data_next   = shift_reg[FRAME_LEN-1 -: DATA_W];
               valid_next  = 1'b1;
               strobe_next = 1'b1;
            end else begin
               perr_next  = 1'b1;
               valid_next = 1'b0;
            end
            count_next = '0;
            state_next = IDLE;
            // A strobe landing in the check cycle starts the next frame.
            if (edge_reg) begin
               shift_next  = {shift_reg[FRAME_LEN-2:0], bit_reg};
               count_next  = CNT_W'(1);
               tcount_next = '0;
               state_next  = SHIFT;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign link.mbed_data   = data_reg;
   assign link.data_valid  = valid_reg;
   assign link.data_strobe = strobe_reg;
   assign link.parity_err  = perr_reg;
   assign link.frame_err   = ferr_reg;
endmodule

// File: tb/tb_mbed_serial_receiver.sv
// Scoreboard bench for mbed_serial_receiver: parity and no-parity instances
// driven over randomised strobe timing, checked against a frame-level model.
module tb_mbed_serial_receiver;
   import mbed_serial_receiver_pkg::*;

   localparam int DW  = 11;
   localparam int TO  = 200;
   localparam int SS  = 2;
   localparam int LAT = SS + 2;

   typedef struct {
      int          kind;   // 0 strobe, 1 parity error, 2 frame error
      logic [DW-1:0] data;
      logic        valid;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   perr_n_seen = 0;

   exp_t qp[$];
   exp_t qn[$];

   logic [DW-1:0] mdl_data_p = '0;
   logic [DW-1:0] mdl_data_n = '0;
   logic          mdl_valid_p = 1'b0;
   logic          mdl_valid_n = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mbed_serial_receiver_if #(.DATA_W(DW)) ifp ();
   mbed_serial_receiver_if #(.DATA_W(DW)) ifn ();

   mbed_serial_receiver #(.DATA_W(DW), .PARITY_EN(1), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut_p (
      .clk(clk), .rst_n(rst_n), .link(ifp.slave)
   );

   mbed_serial_receiver #(.DATA_W(DW), .PARITY_EN(0), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut_n (
      .clk(clk), .rst_n(rst_n), .link(ifn.slave)
   );

   function automatic exp_t mk(input int k, input logic [DW-1:0] d, input logic v, input int c);
      exp_t e;
      e.kind = k; e.data = d; e.valid = v; e.cyc = c;
      return e;
   endfunction

   task automatic compare_event(input string nm, input bit have, input exp_t e, input int k,
                                input int nact, input logic [DW-1:0] d, input logic v);
      checks++;
      if (!have) begin
         errors++;
         $display("FAIL %s unexpected event: kind=%0d data=%h valid=%b at cyc %0d, required no event",
                  nm, k, d, v, cyc);
      end else if (nact != 1 || e.kind != k || e.data !== d || e.valid !== v || e.cyc != cyc) begin
         errors++;
         $display("FAIL %s event: kind=%0d pulses=%0d data=%h valid=%b cyc=%0d, required kind=%0d data=%h valid=%b cyc=%0d",
                  nm, k, nact, d, v, cyc, e.kind, e.data, e.valid, e.cyc);
      end else begin
         $display("%s event kind=%0d data=%h valid=%b cyc=%0d ok", nm, k, d, v, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   k, nact;
      bit   have;
      if (rst_n) begin
         nact = int'(ifp.data_strobe) + int'(ifp.parity_err) + int'(ifp.frame_err);
         if (nact != 0) begin
            k = ifp.frame_err ? 2 : (ifp.parity_err ? 1 : 0);
            have = (qp.size() != 0);
            if (have) e = qp.pop_front();
            compare_event("par", have, e, k, nact, ifp.mbed_data, ifp.data_valid);
         end
         if (ifn.parity_err) perr_n_seen++;
         nact = int'(ifn.data_strobe) + int'(ifn.parity_err) + int'(ifn.frame_err);
         if (nact != 0) begin
            k = ifn.frame_err ? 2 : (ifn.parity_err ? 1 : 0);
            have = (qn.size() != 0);
            if (have) e = qn.pop_front();
            compare_event("nopar", have, e, k, nact, ifn.mbed_data, ifn.data_valid);
         end
      end
   end

   task automatic drive(input bit sel, input logic s, input logic b);
      if (sel) begin ifn.set_bit = s; ifn.input_bit = b; end
      else begin ifp.set_bit = s; ifp.input_bit = b; end
   endtask

   // Present data, hold it lo cycles, then raise the strobe; returns the
   // cycle number of the clock edge that first registers the rise.
   task automatic bit_rise(input bit sel, input logic b, input int lo, output int rc);
      drive(sel, 1'b0, b);
      repeat (lo) @(negedge clk);
      drive(sel, 1'b1, b);
      rc = cyc + 1;
   endtask

   task automatic bit_fall(input bit sel, input logic b, input int hi);
      repeat (hi) @(negedge clk);
      drive(sel, 1'b0, b);
   endtask

   // Frame-level model: a complete frame is good iff parity is off or the
   // XOR over word and parity bit is 1; the result appears LAT cycles later.
   task automatic send_frame(input bit sel, input logic [DW-1:0] w, input logic p,
                             input int lo, input int hi);
      logic [DW:0] fr;
      int          n, rc;
      logic        b;
      fr = {w, p};
      n  = sel ? DW : DW + 1;
      $display("send %s word=%h par=%b lo=%0d hi=%0d", sel ? "nopar" : "par", w, p, lo, hi);
      for (int i = 0; i < n; i++) begin
         b = sel ? w[DW-1-i] : fr[DW-i];
         bit_rise(sel, b, lo, rc);
         if (i == n - 1) begin
            if (sel) begin
               mdl_data_n = w; mdl_valid_n = 1'b1;
               qn.push_back(mk(0, w, 1'b1, rc + LAT));
            end else if (^fr) begin
               mdl_data_p = w; mdl_valid_p = 1'b1;
               qp.push_back(mk(0, w, 1'b1, rc + LAT));
            end else begin
               mdl_valid_p = 1'b0;
               qp.push_back(mk(1, mdl_data_p, 1'b0, rc + LAT));
            end
         end
         bit_fall(sel, b, hi);
      end
   endtask

   task automatic send_partial(input logic [DW:0] fr, input int nb, output int rc);
      $display("send par partial frame=%h bits=%0d", fr, nb);
      rc = 0;
      for (int i = 0; i < nb; i++) begin
         bit_rise(1'b0, fr[DW-i], 3, rc);
         bit_fall(1'b0, fr[DW-i], 3);
      end
   endtask

   task automatic check_levels(input string tag);
      checks++;
      if (ifp.mbed_data !== mdl_data_p || ifp.data_valid !== mdl_valid_p) begin
         errors++;
         $display("FAIL levels_par %s: data=%h valid=%b, required data=%h valid=%b",
                  tag, ifp.mbed_data, ifp.data_valid, mdl_data_p, mdl_valid_p);
      end
      checks++;
      if (ifn.mbed_data !== mdl_data_n || ifn.data_valid !== mdl_valid_n) begin
         errors++;
         $display("FAIL levels_nopar %s: data=%h valid=%b, required data=%h valid=%b",
                  tag, ifn.mbed_data, ifn.data_valid, mdl_data_n, mdl_valid_n);
      end
   endtask

   task automatic check_zero(input string tag);
      checks++;
      if (ifp.mbed_data !== '0 || ifp.data_valid !== 1'b0 || ifp.data_strobe !== 1'b0 ||
          ifp.parity_err !== 1'b0 || ifp.frame_err !== 1'b0 ||
          ifn.mbed_data !== '0 || ifn.data_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s: par data=%h valid=%b strobe=%b perr=%b ferr=%b nopar data=%h valid=%b, required all zero",
                  tag, ifp.mbed_data, ifp.data_valid, ifp.data_strobe, ifp.parity_err,
                  ifp.frame_err, ifn.mbed_data, ifn.data_valid);
      end
   endtask

   task automatic settle();
      repeat (LAT + 2) @(negedge clk);
   endtask

   initial begin
      int            rc, lo, hi;
      logic [DW-1:0] w;
      logic          p;

      drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      send_frame(1'b0, 11'h580, 1'b0, 3, 3);
      settle();
      check_levels("good_580");

      send_frame(1'b0, 11'h65A, 1'b0, 3, 4);
      settle();
      check_levels("bad_parity_65a");

      // Stall after five bits: frame error TO-1 cycles after a strobe would have been due.
      send_partial({11'h3C3, 1'b1}, 5, rc);
      mdl_valid_p = 1'b0;
      qp.push_back(mk(2, mdl_data_p, 1'b0, rc + LAT + TO - 1));
      repeat (TO + 10) @(negedge clk);
      check_levels("timeout");
      send_frame(1'b0, 11'h65A, 1'b1, 3, 3);
      settle();
      check_levels("after_timeout_65a");

      for (int i = 0; i < 2; i++) begin
         w = DW'($urandom());
         send_frame(1'b0, w, ~(^w), 3, 3);
      end
      settle();
      check_levels("back_to_back");

      send_partial({11'h2AA, 1'b0}, 7, rc);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("reset_mid_frame");
      mdl_data_p = '0; mdl_valid_p = 1'b0;
      mdl_data_n = '0; mdl_valid_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(1'b0, 11'h1B7, ~(^11'h1B7), 4, 3);
      settle();
      check_levels("after_reset");

      send_frame(1'b1, 11'h7FF, 1'b0, 3, 3);
      settle();
      check_levels("nopar_7ff");
      for (int i = 0; i < 3; i++) begin
         send_frame(1'b1, DW'($urandom()), 1'b0, $urandom_range(3, 5), $urandom_range(3, 5));
      end
      settle();
      check_levels("nopar_random");

      for (int i = 0; i < 20; i++) begin
         w  = DW'($urandom());
         p  = ($urandom_range(0, 3) == 0) ? (^w) : ~(^w);
         lo = $urandom_range(3, 5);
         hi = $urandom_range(3, 5);
         send_frame(1'b0, w, p, lo, hi);
         repeat ($urandom_range(0, 8)) @(negedge clk);
      end
      settle();
      check_levels("random_end");

      repeat (20) @(negedge clk);
      checks++;
      if (qp.size() != 0 || qn.size() != 0) begin
         errors++;
         $display("FAIL missing_events: pending par=%0d nopar=%0d, required 0 0", qp.size(), qn.size());
      end
      checks++;
      if (perr_n_seen != 0) begin
         errors++;
         $display("FAIL nopar_parity_err: pulses=%0d, required 0", perr_n_seen);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mbed_serial_receiver.md
Name: mbed_serial_receiver

Overview:
Upstream stage of the servo controller. Deserialises the two-wire strobe/data link from the mbed into the 11-bit instruction word (activation, mode, servo select, 8-bit value) consumed by the top-level servo dispatch logic. It synchronises the asynchronous link signals, checks an optional odd-parity bit and aborts stalled frames on timeout. It presents a held word plus valid/strobe flags, and drops valid on any link error so that downstream logic disables both servos.

Parameters:
DATA_W, 11, instruction word width (bit 10 activation, bit 9 maintenance/running, bit 8 servo select, bits 7:0 value)
PARITY_EN, 1, 1 = frame carries a trailing odd-parity bit; 0 = no parity bit
TIMEOUT_CYCLES, 50000, clk cycles allowed between consecutive strobe edges inside a frame (1 ms at 50 MHz)
SYNC_STAGES, 2, synchroniser flops on set_bit and input_bit (minimum 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
set_bit  in  1  async bit strobe from mbed; data sampled on rising edge
input_bit  in  1  async serial data from mbed, MSB first
mbed_data  out  DATA_W  last good instruction word, held
data_valid  out  1  level: mbed_data holds a good word
data_strobe  out  1  one-cycle pulse when mbed_data updates
parity_err  out  1  one-cycle pulse: completed frame failed parity
frame_err  out  1  one-cycle pulse: partial frame aborted on timeout

Behaviour:
- Reset (async assert, sync deassert by the clk domain): mbed_data=0, data_valid=0, data_strobe=0, parity_err=0, frame_err=0, FSM=IDLE, bit count=0, timeout count=0, all sync flops=0.
- set_bit and input_bit each pass through SYNC_STAGES flops. A rising edge is sync_out & ~prev. input_bit is sampled from its synchroniser output in the edge cycle.
- Link constraints on the mbed side: set_bit high for at least 3 clk and low for at least 3 clk. input_bit is stable from 2 clk before to 2 clk after each set_bit rise.
- FRAME_LEN = DATA_W + PARITY_EN (12 by default). Bits shift in MSB first; the parity bit is last.
- FSM states:
  - IDLE: on an edge, shift in bit 0, count=1, clear the timeout counter, go to SHIFT.
  - SHIFT: on an edge, shift in the next bit, count+1, clear the timeout counter. When count reaches FRAME_LEN, go to CHECK.
  - SHIFT timeout: with no edge, the timeout counter increments. When it reaches TIMEOUT_CYCLES-1, pulse frame_err, clear data_valid, discard the partial frame and return to IDLE.
  - CHECK (one cycle): if parity passes (XOR of all FRAME_LEN bits = 1, or PARITY_EN=0), load mbed_data from the data bits, set data_valid=1 and pulse data_strobe. Otherwise pulse parity_err, clear data_valid and leave mbed_data unchanged. Go to IDLE.
  - An edge detected in the CHECK cycle is taken as bit 0 of the next frame; go to SHIFT with count=1.
- Latency: data_strobe is high in the clk cycle (SYNC_STAGES+2) cycles after the final set_bit rise is first registered, which is 4 cycles at the default. mbed_data and data_valid change in that same cycle.
- No timeout in IDLE: the link may idle indefinitely with data_valid held.
- A new good frame overwrites mbed_data. There is no ack; data_valid stays 1 across successive good frames.
- All error and strobe outputs are single-cycle pulses and never overlap.
- Reset mid-frame discards all partial state immediately.
- The timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates; it never wraps.

Decomposition:
- Shared package holds: the word-field bit positions (ACT_BIT=10, MODE_BIT=9, SERVO_BIT=8, VALUE_MSB=7), the FSM state encoding (IDLE, SHIFT, CHECK) and the default DATA_W.
- One sub-module is natural: bit_synchronizer (parameter SYNC_STAGES, width 1), instantiated once each for set_bit and input_bit.

Test Plan:
- Good frame, default parameters, bits 1011_0000_000 plus parity 0 (word 0x580) -> data_strobe pulse, mbed_data=0x580, data_valid=1, 4 cycles after the last strobe is registered.
- Bad parity: word 0x65A sent with parity bit 0 -> parity_err pulse, data_valid=0, mbed_data keeps its previous value 0x580.
- Stalled frame: 5 bits sent, then set_bit held low for TIMEOUT_CYCLES -> frame_err pulse at exactly TIMEOUT_CYCLES-1 idle cycles. A following full frame 0x65A with parity 1 is then accepted.
- Back-to-back frames at minimum strobe spacing (3 clk high, 3 clk low) -> two data_strobe pulses; mbed_data updates to the second word with no lost bits.
- rst_n asserted after 7 bits of a frame -> all outputs read 0 immediately. The next full frame is received correctly from bit 0.
- PARITY_EN=0, 11-bit frame 0x7FF -> data_strobe, mbed_data=0x7FF, and parity_err never asserts.
